adder4b_bist: RTL and testbench

Built-in self-test engine for the 4-bit ripple adder (`Adder4b`: ports `A[3:0]`, `B[3:0]`, `Cin`, `S[3:0]`, `Cout`).

- **Function:** on `start`, it sweeps all 512 `{Cin,A,B}` vectors into the adder. For each vector it samples `S`/`Cout`, compares them against a golden `A+B+Cin`, counts mismatches and latches the first failing vector.
- **Placement:** sits on the board next to the adder instance, so the adder can be verified in hardware without a simulator.

---
 rtl/adder4b_bist.sv | 140 ++++++++++++++
 tb/tb_adder4b_bist.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder4b_bist.sv
// adder4b_bist: built-in self-test engine for a 4-bit ripple adder.
//
// On start, sweeps all 512 {Cin,A,B} vectors into the adder, waits SETTLE
// cycles per vector, compares {Cout,S} against A+B+Cin, counts mismatches
// (saturating) and latches the first failing vector.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   start a sweep (honoured in IDLE or DONE only)
//   dut_A/B    out  registered operands to the adder
//   dut_Cin    out  registered carry-in to the adder
//   dut_S      in   sum from the adder
//   dut_Cout   in   carry-out from the adder
//   busy       out  high in WAIT and CHECK
//   done       out  high in DONE
//   pass       out  high in DONE with no mismatches
//   err_cnt    out  mismatch count, saturating
//   first_fail out  {Cin,A,B} of the first mismatch
//   fail_valid out  first_fail holds a value
module adder4b_bist #(
    parameter int SETTLE = 1,
    parameter int ERR_W  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [3:0]       dut_A,
    output logic [3:0]       dut_B,
    output logic             dut_Cin,
    input  logic [3:0]       dut_S,
    input  logic             dut_Cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [8:0]       first_fail,
    output logic             fail_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [3:0]       L_WLOAD = 4'(SETTLE - 1);
    localparam logic [ERR_W-1:0] L_ONE   = {{(ERR_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [8:0]       r_v;
    logic [3:0]       r_wcnt;
    logic [ERR_W-1:0] r_err;
    logic [8:0]       r_first;
    logic             r_fvalid;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;

    logic [4:0]       w_exp;
    logic             w_mismatch;
    logic [ERR_W-1:0] w_err_inc;

    always_comb begin
        w_exp      = {1'b0, r_v[7:4]} + {1'b0, r_v[3:0]} + {4'b0, r_v[8]};
        w_mismatch = (w_exp != {dut_Cout, dut_S});
        w_err_inc  = (r_err == '1) ? r_err : r_err + L_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_v      <= '0;
            r_wcnt   <= '0;
            r_err    <= '0;
            r_first  <= '0;
            r_fvalid <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_v      <= '0;
                        r_err    <= '0;
                        r_first  <= '0;
                        r_fvalid <= 1'b0;
                        r_wcnt   <= L_WLOAD;
                        r_state  <= S_WAIT;
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
                        r_pass   <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (r_wcnt == 4'd0) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_wcnt <= r_wcnt - 4'd1;
                    end
                end
                S_CHECK: begin
                    if (w_mismatch) begin
                        r_err <= w_err_inc;
                        if (!r_fvalid) begin
                            r_first  <= r_v;
                            r_fvalid <= 1'b1;
                        end
                    end
                    if (r_v == 9'd511) begin
                        // Operands stay on the last vector while in DONE.
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        // Counter saturates, never wraps, so zero means clean.
                        r_pass  <= !w_mismatch && (r_err == '0);
                    end else begin
                        r_v     <= r_v + 9'd1;
                        r_wcnt  <= L_WLOAD;
                        r_state <= S_WAIT;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dut_Cin    = r_v[8];
    assign dut_A      = r_v[7:4];
    assign dut_B      = r_v[3:0];
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_cnt    = r_err;
    assign first_fail = r_first;
    assign fail_valid = r_fvalid;

endmodule

// File: tb/tb_adder4b_bist.sv
// Testbench for adder4b_bist: two engines (default, and SETTLE=3/ERR_W=6)
// each driving a behavioural adder with selectable faults.
module tb_adder4b_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start0, start1;
    int   mode0, mode1;   // 0 good, 1 S[0] stuck 0, 2 Cout stuck 0, 3 S[1] flipped per table
    logic flip0 [512];
    logic flip1 [512];

    logic [3:0] a0, b0, s0, a1, b1, s1;
    logic       c0, co0, busy0, done0, pass0, fv0;
    logic       c1, co1, busy1, done1, pass1, fv1;
    logic [9:0] err0;
    logic [5:0] err1;
    logic [8:0] ff0, ff1;

    int total = 0;
    int bad   = 0;
    int sel   = 0;

    function automatic logic [4:0] adder_model(input logic [8:0] v, input int mode, input logic flip);
        logic [4:0] r;
        r = 5'(v[7:4]) + 5'(v[3:0]) + 5'(v[8]);
        case (mode)
            1: r[0] = 1'b0;
            2: r[4] = 1'b0;
            3: if (flip) r[1] = ~r[1];
            default: ;
        endcase
        return r;
    endfunction

    assign {co0, s0} = adder_model({c0, a0, b0}, mode0, flip0[{c0, a0, b0}]);
    assign {co1, s1} = adder_model({c1, a1, b1}, mode1, flip1[{c1, a1, b1}]);

    adder4b_bist u_dut0 (
        .clk(clk), .rst(rst), .start(start0),
        .dut_A(a0), .dut_B(b0), .dut_Cin(c0), .dut_S(s0), .dut_Cout(co0),
        .busy(busy0), .done(done0), .pass(pass0),
        .err_cnt(err0), .first_fail(ff0), .fail_valid(fv0)
    );

    adder4b_bist #(.SETTLE(3), .ERR_W(6)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .dut_A(a1), .dut_B(b1), .dut_Cin(c1), .dut_S(s1), .dut_Cout(co1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(err1), .first_fail(ff1), .fail_valid(fv1)
    );

    // View of whichever engine is under test.
    logic       m_busy, m_done, m_pass, m_fv;
    logic [9:0] m_err;
    logic [8:0] m_ff, m_vec;
    always_comb begin
        m_busy = (sel != 0) ? busy1 : busy0;
        m_done = (sel != 0) ? done1 : done0;
        m_pass = (sel != 0) ? pass1 : pass0;
        m_fv   = (sel != 0) ? fv1   : fv0;
        m_err  = (sel != 0) ? 10'(err1) : err0;
        m_ff   = (sel != 0) ? ff1   : ff0;
        m_vec  = (sel != 0) ? {c1, a1, b1} : {c0, a0, b0};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive_start(input logic v);
        if (sel != 0) start1 = v;
        else          start0 = v;
    endtask

    // Expected sweep outcome from plain arithmetic over all 512 vectors.
    task automatic model(input int errw, output int ecnt, output int first, output int fval);
        int         mode;
        logic       fl;
        logic [8:0] vv;
        int         golden;
        ecnt  = 0;
        first = 0;
        fval  = 0;
        mode  = (sel != 0) ? mode1 : mode0;
        for (int v = 0; v < 512; v++) begin
            vv     = 9'(v);
            fl     = (sel != 0) ? flip1[v] : flip0[v];
            golden = ((v >> 4) & 15) + (v & 15) + (v >> 8);
            if (int'(adder_model(vv, mode, fl)) != golden) begin
                ecnt++;
                if (fval == 0) begin
                    first = v;
                    fval  = 1;
                end
            end
        end
        if (ecnt > (1 << errw) - 1) ecnt = (1 << errw) - 1;
    endtask

    // Start a sweep, follow it to DONE, check timing and results.
    // poke_at >= 0 pulses start that many cycles into the sweep.
    task automatic run(input int settle, input int errw, input int poke_at);
        int k, since, busy_cnt, done_k, step_err, both, ecnt, first, fval;
        logic [8:0] last;
        @(negedge clk);
        drive_start(1'b1);
        @(posedge clk);
        #1;
        drive_start(1'b0);
        check("start_busy", m_busy, 1);
        check("start_vec0", m_vec, 0);
        check("start_err_clr", m_err, 0);
        check("start_fv_clr", m_fv, 0);
        k = 0; since = 0; busy_cnt = 1; done_k = -1; step_err = 0; both = 0; last = '0;
        while (!m_done) begin
            if (k > 600 * (settle + 1)) begin
                check("sweep_timeout", 0, 1);
                return;
            end
            @(posedge clk);
            #1;
            k++;
            since++;
            if (k == poke_at)     drive_start(1'b1);
            if (k == poke_at + 1) drive_start(1'b0);
            if (m_busy && m_done) both++;
            if (m_busy) busy_cnt++;
            if (m_done) done_k = k;
            if (m_vec != last) begin
                if (m_vec != last + 9'd1 || since != settle + 1) step_err++;
                last  = m_vec;
                since = 0;
            end
        end
        check("busy_cycles", busy_cnt, 512 * (settle + 1));
        check("done_edge", done_k, 512 * (settle + 1));
        check("operand_steps", step_err, 0);
        check("busy_and_done", both, 0);
        model(errw, ecnt, first, fval);
        check("err_cnt", m_err, ecnt);
        check("first_fail", m_ff, first);
        check("fail_valid", m_fv, fval);
        check("pass", m_pass, (ecnt == 0) ? 1 : 0);
        check("hold_last_vec", m_vec, 511);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, m_busy, 0);
        check({tag, "_done"}, m_done, 0);
        check({tag, "_pass"}, m_pass, 0);
        check({tag, "_err"},  m_err, 0);
        check({tag, "_ff"},   m_ff, 0);
        check({tag, "_fv"},   m_fv, 0);
        check({tag, "_vec"},  m_vec, 0);
    endtask

    initial begin
        mode0 = 0; mode1 = 0;
        for (int i = 0; i < 512; i++) begin
            flip0[i] = 1'b0;
            flip1[i] = 1'b0;
        end
        // start held during reset must be ignored.
        rst = 1'b1; start0 = 1'b1; start1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sel = 0; check_reset_outputs("rst0");
        sel = 1; check_reset_outputs("rst1");
        @(negedge clk);
        rst = 1'b0; start0 = 1'b0; start1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        sel = 0;
        check("idle_busy", m_busy, 0);

        // Good adder, SETTLE=1.
        sel = 0; mode0 = 0;
        run(1, 10, -1);
        // S[0] stuck at 0, restarted from DONE.
        mode0 = 1;
        run(1, 10, -1);
        check("s0_err256", m_err, 256);
        check("s0_first", m_ff, 9'h001);
        // Cout stuck at 0, restarted from DONE with prior errors present.
        mode0 = 2;
        run(1, 10, -1);
        check("cout_err256", m_err, 256);
        check("cout_first", m_ff, 9'h01F);
        // Start pulses mid-sweep are ignored.
        run(1, 10, 301);

        // Random single-bit faults, first vector forced faulty.
        mode0 = 3;
        for (int i = 0; i < 512; i++) flip0[i] = ($urandom_range(7) == 0);
        flip0[0] = 1'b1;
        run(1, 10, -1);
        check("first_vec_fail", m_ff, 0);
        // Random faults with a clean first vector.
        for (int i = 0; i < 512; i++) flip0[i] = ($urandom_range(5) == 0);
        flip0[0] = 1'b0;
        run(1, 10, -1);

        // Reset mid-sweep, with start asserted on the same edge.
        mode0 = 1;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (300) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; start0 = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0; start0 = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_idle", m_busy, 0);
        run(1, 10, -1);

        // SETTLE=3 engine: good adder, then saturating counter.
        sel = 1; mode1 = 0;
        run(3, 6, -1);
        mode1 = 1;
        run(3, 6, -1);
        check("sat_err", m_err, 63);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
